// File: rtl/scan_pkg.sv
// Shared definitions for the scan select sequencer: state encoding, default
// timing and the wrap-around next-digit search.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam int DEF_DIV_W     = 16;
    localparam int DEF_DIV_MAX   = 49999;
    localparam int DEF_BLANK_CYC = 4;

    // Smallest enabled digit above sel, else wrap to the smallest enabled digit.
    function automatic logic [1:0] next_sel(input logic [1:0] sel, input logic [3:0] mask);
        logic [1:0] r;
        logic       hit;
        r   = 2'd0;
        hit = 1'b0;
        for (int j = 3; j >= 0; j--) begin
            if (mask[j] && (j > int'(sel))) begin
                r   = 2'(j);
                hit = 1'b1;
            end
        end
        if (!hit) begin
            for (int j = 3; j >= 0; j--) begin
                if (mask[j]) begin
                    r = 2'(j);
                end
            end
        end
        return r;
    endfunction

    // Nothing lies above digit 3, so the search always wraps to the lowest set bit.
    function automatic logic [1:0] first_sel(input logic [3:0] mask);
        return next_sel(2'd3, mask);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell counter for free-run scanning: counts while run is high and emits a
// one-clock tick on the last clock of each DIV_MAX+1 clock dwell.
module scan_prescaler #(
    parameter int DIV_W   = 16,
    parameter int DIV_MAX = 49999
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             at_max;

    assign at_max = (cnt_q == DIV_W'(DIV_MAX));
    assign tick   = run && !clr && at_max;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_sel_seq.sv
// Scan sequencer driving a 2-to-4 decoder's select pair and active-low enable,
// with masked digits skipped and blanking dead time around every select change.
module scan_sel_seq
    import scan_pkg::*;
#(
    parameter int DIV_W     = DEF_DIV_W,
    parameter int DIV_MAX   = DEF_DIV_MAX,
    parameter int BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic       MODE,
    input  logic       STEP,
    input  logic [3:0] MASK,
    output logic       A,
    output logic       B,
    output logic       G_L,
    output logic       FRAME
);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] target_q, target_d;
    logic [3:0] blank_cnt_q, blank_cnt_d;
    logic       gl_q, gl_d;
    logic       frame_q, frame_d;
    logic       step_q;

    logic       tick;
    logic       step_rise;
    logic       advance;
    logic [1:0] adv_target;
    logic       div_clr;
    logic       div_run;

    assign step_rise  = STEP && !step_q;
    assign adv_target = next_sel(sel_q, MASK);
    // Divider only runs while a digit is shown in free-run; otherwise it sits at zero.
    assign div_run    = (state_q == ST_SHOW) && !MODE;
    assign div_clr    = !div_run;

    scan_prescaler #(
        .DIV_W  (DIV_W),
        .DIV_MAX(DIV_MAX)
    ) u_prescaler (
        .clk (CLK),
        .srst(RESET),
        .clr (div_clr),
        .run (div_run),
        .tick(tick)
    );

    always_comb begin
        advance = 1'b0;
        if (state_q == ST_SHOW) begin
            if (!MASK[sel_q]) begin
                advance = 1'b1;
            end else if (!MODE) begin
                advance = tick;
            end else begin
                advance = step_rise;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        target_d    = target_q;
        blank_cnt_d = blank_cnt_q;
        frame_d     = 1'b0;
        if (!EN || (MASK == 4'b0000)) begin
            state_d     = ST_IDLE;
            blank_cnt_d = 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d     = ST_BLANK;
                    target_d    = first_sel(MASK);
                    blank_cnt_d = 4'd0;
                    frame_d     = 1'b1;
                end
                ST_BLANK: begin
                    // Select moves only after G_L has been high for a full clock.
                    if (blank_cnt_q == 4'd0) begin
                        sel_d = target_q;
                    end
                    if (blank_cnt_q == 4'(BLANK_CYC - 1)) begin
                        state_d     = ST_SHOW;
                        blank_cnt_d = 4'd0;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 4'd1;
                    end
                end
                ST_SHOW: begin
                    if (advance) begin
                        state_d     = ST_BLANK;
                        target_d    = adv_target;
                        blank_cnt_d = 4'd0;
                        frame_d     = (adv_target <= sel_q);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        gl_d = (state_d != ST_SHOW);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            target_q    <= 2'd0;
            blank_cnt_q <= 4'd0;
            gl_q        <= 1'b1;
            frame_q     <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            target_q    <= target_d;
            blank_cnt_q <= blank_cnt_d;
            gl_q        <= gl_d;
            frame_q     <= frame_d;
            step_q      <= STEP;
        end
    end

    assign A     = sel_q[0];
    assign B     = sel_q[1];
    assign G_L   = gl_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_scan_sel_seq.sv
// Self-checking bench for scan_sel_seq: scoreboard of expected shown digits
// plus per-scenario checks of blanking, framing and control priority.
module tb_scan_sel_seq;

    localparam int DIV_MAX   = 3;
    localparam int BLANK_CYC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       step = 1'b0;
    logic [3:0] mask = 4'b0000;
    logic       a, b, g_l, frame;

    int checks = 0;
    int failures = 0;

    logic [1:0] sb_q[$];
    logic       len_chk = 1'b0;
    logic       sb_strict = 1'b0;
    int         frame_cnt = 0;
    logic [1:0] frame_sel = 2'd0;

    scan_sel_seq #(
        .DIV_W    (16),
        .DIV_MAX  (DIV_MAX),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .CLK  (clk),
        .RESET(reset),
        .EN   (en),
        .MODE (mode),
        .STEP (step),
        .MASK (mask),
        .A    (a),
        .B    (b),
        .G_L  (g_l),
        .FRAME(frame)
    );

    always #5 clk = ~clk;

    // Monitor: scoreboard pops at each show start, glitch and dwell checks.
    logic [1:0] prev_sel = 2'd0;
    logic       prev_gl = 1'b1;
    logic       rst_prev = 1'b1;
    int         show_len = 0;
    int         blank_len = 0;

    always @(negedge clk) begin
        logic [1:0] cur_sel;
        logic [1:0] exp_sel;
        cur_sel = {b, a};
        if (rst_prev) begin
            show_len  = 0;
            blank_len = 0;
        end else begin
            if (cur_sel !== prev_sel) begin
                checks++;
                if (!(g_l === 1'b1 && prev_gl === 1'b1)) begin
                    failures++;
                    $display("FAIL glitch: sel %0d->%0d with G_L %b->%b, required G_L high before and after", prev_sel, cur_sel, prev_gl, g_l);
                end
            end
            if (prev_gl === 1'b1 && g_l === 1'b0) begin
                if (len_chk) begin
                    checks++;
                    if (blank_len !== BLANK_CYC) begin
                        failures++;
                        $display("FAIL blank_len: got %0d required %0d", blank_len, BLANK_CYC);
                    end
                end
                if (sb_q.size() > 0) begin
                    exp_sel = sb_q.pop_front();
                    checks++;
                    if (cur_sel !== exp_sel) begin
                        failures++;
                        $display("FAIL show_sel: got %0d required %0d", cur_sel, exp_sel);
                    end
                end else if (sb_strict) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_show: got sel %0d required no new show", cur_sel);
                end
                show_len = 0;
            end
            if (prev_gl === 1'b0 && g_l === 1'b1) begin
                if (len_chk) begin
                    checks++;
                    if (show_len !== DIV_MAX + 1) begin
                        failures++;
                        $display("FAIL show_len: got %0d required %0d", show_len, DIV_MAX + 1);
                    end
                end
                blank_len = 0;
            end
            if (g_l === 1'b0) show_len++;
            else blank_len++;
            if (frame === 1'b1) begin
                frame_cnt++;
                frame_sel = cur_sel;
            end
        end
        prev_sel = cur_sel;
        prev_gl  = g_l;
        rst_prev = reset;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        len_chk   = 1'b0;
        sb_strict = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int f_at;
        int g_at;
        int f_n;
        en = 1'b1; mode = 1'b0; mask = 4'b1111;
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        repeat (2) @(negedge clk);
        checks++;
        if ({b, a} !== 2'b00) begin failures++; $display("FAIL reset_sel: got %b required 00", {b, a}); end
        checks++;
        if (g_l !== 1'b1) begin failures++; $display("FAIL reset_gl: got %b required 1", g_l); end
        checks++;
        if (frame !== 1'b0) begin failures++; $display("FAIL reset_frame: got %b required 0", frame); end
        sb_q.push_back(2'd0);
        reset = 1'b0;
        f_at = -1; g_at = -1; f_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame === 1'b1) begin f_n++; f_at = i; end
            if (g_l === 1'b0) begin g_at = i; break; end
        end
        checks++;
        if (f_n !== 1) begin failures++; $display("FAIL reset_frame_count: got %0d required 1", f_n); end
        checks++;
        if (g_at - f_at !== BLANK_CYC) begin failures++; $display("FAIL reset_blank_delay: got %0d required %0d", g_at - f_at, BLANK_CYC); end
        checks++;
        if ({b, a} !== 2'd0) begin failures++; $display("FAIL reset_first_sel: got %0d required 0", {b, a}); end
    endtask

    task automatic test_free_run();
        int f0;
        int seen;
        en = 1'b1; mode = 1'b0; mask = 4'b1111;
        do_reset();
        sb_q.push_back(2'd0); sb_q.push_back(2'd1); sb_q.push_back(2'd2);
        sb_q.push_back(2'd3); sb_q.push_back(2'd0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (g_l === 1'b0) begin seen = 1; break; end
        end
        checks++;
        if (seen !== 1) begin failures++; $display("FAIL free_first_show: got timeout required show"); end
        @(negedge clk);
        len_chk = 1'b1;
        f0 = frame_cnt;
        wait_drain(200);
        len_chk = 1'b0;
        checks++;
        if (sb_q.size() !== 0) begin failures++; $display("FAIL free_drain: got %0d pending required 0", sb_q.size()); end
        checks++;
        if (frame_cnt - f0 !== 1) begin failures++; $display("FAIL free_frame_count: got %0d required 1", frame_cnt - f0); end
        checks++;
        if (frame_sel !== 2'd3) begin failures++; $display("FAIL free_frame_at: got sel %0d required 3", frame_sel); end
    endtask

    task automatic test_mask_sparse();
        int f0;
        en = 1'b1; mode = 1'b0; mask = 4'b1010;
        do_reset();
        f0 = frame_cnt;
        sb_q.push_back(2'd1); sb_q.push_back(2'd3); sb_q.push_back(2'd1); sb_q.push_back(2'd3);
        wait_drain(200);
        checks++;
        if (sb_q.size() !== 0) begin failures++; $display("FAIL sparse_drain: got %0d pending required 0", sb_q.size()); end
        checks++;
        if (frame_cnt - f0 !== 2) begin failures++; $display("FAIL sparse_frame_count: got %0d required 2", frame_cnt - f0); end
        checks++;
        if (frame_sel !== 2'd3) begin failures++; $display("FAIL sparse_frame_at: got sel %0d required 3", frame_sel); end
        mask = 4'b0100;
        sb_q.push_back(2'd2);
        @(negedge clk);
        checks++;
        if (g_l !== 1'b1) begin failures++; $display("FAIL maskoff_gl: got %b required 1", g_l); end
        checks++;
        if (frame !== 1'b1) begin failures++; $display("FAIL maskoff_frame: got %b required 1", frame); end
        wait_drain(50);
        checks++;
        if (sb_q.size() !== 0) begin failures++; $display("FAIL maskoff_drain: got %0d pending required 0", sb_q.size()); end
    endtask

    task automatic test_mask_zero();
        int f0;
        en = 1'b1; mode = 1'b0; mask = 4'b1111;
        do_reset();
        sb_q.push_back(2'd0); sb_q.push_back(2'd1);
        wait_drain(100);
        mask = 4'b0000;
        f0 = frame_cnt;
        @(negedge clk);
        checks++;
        if (g_l !== 1'b1) begin failures++; $display("FAIL zero_gl: got %b required 1", g_l); end
        checks++;
        if ({b, a} !== 2'd1) begin failures++; $display("FAIL zero_sel: got %0d required 1", {b, a}); end
        repeat (3) @(negedge clk);
        checks++;
        if (g_l !== 1'b1 || {b, a} !== 2'd1) begin failures++; $display("FAIL zero_idle: got G_L=%b sel=%0d required G_L=1 sel=1", g_l, {b, a}); end
        checks++;
        if (frame_cnt !== f0) begin failures++; $display("FAIL zero_no_frame: got %0d pulses required 0", frame_cnt - f0); end
        mask = 4'b0001;
        sb_q.push_back(2'd0);
        @(negedge clk);
        checks++;
        if (frame !== 1'b1) begin failures++; $display("FAIL restart_frame: got %b required 1", frame); end
        wait_drain(50);
        checks++;
        if (sb_q.size() !== 0) begin failures++; $display("FAIL restart_drain: got %0d pending required 0", sb_q.size()); end
    endtask

    task automatic test_manual();
        en = 1'b1; mode = 1'b1; mask = 4'b1111; step = 1'b0;
        do_reset();
        sb_q.push_back(2'd0);
        wait_drain(50);
        sb_strict = 1'b1;
        sb_q.push_back(2'd1);
        step = 1'b1;
        repeat (10) @(negedge clk);
        step = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (sb_q.size() !== 0) begin failures++; $display("FAIL step_hold_adv: got %0d pending required 0", sb_q.size()); end
        checks++;
        if (g_l !== 1'b0 || {b, a} !== 2'd1) begin failures++; $display("FAIL step_hold_once: got G_L=%b sel=%0d required G_L=0 sel=1", g_l, {b, a}); end
        sb_q.push_back(2'd2);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_drain(30);
        checks++;
        if (sb_q.size() !== 0) begin failures++; $display("FAIL step_pulse: got %0d pending required 0", sb_q.size()); end
        repeat (12) @(negedge clk);
        checks++;
        if (g_l !== 1'b0 || {b, a} !== 2'd2) begin failures++; $display("FAIL step_persist: got G_L=%b sel=%0d required G_L=0 sel=2", g_l, {b, a}); end
        sb_strict = 1'b0;
        mode = 1'b0;
    endtask

    task automatic test_en_reset();
        int seen;
        en = 1'b1; mode = 1'b0; mask = 4'b1111;
        do_reset();
        sb_q.push_back(2'd0); sb_q.push_back(2'd1);
        wait_drain(100);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (g_l === 1'b1) begin seen = 1; break; end
        end
        checks++;
        if (seen !== 1) begin failures++; $display("FAIL en_wait_blank: got timeout required blank"); end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (g_l !== 1'b1 || {b, a} !== 2'd1) begin failures++; $display("FAIL en_off: got G_L=%b sel=%0d required G_L=1 sel=1", g_l, {b, a}); end
        repeat (3) @(negedge clk);
        checks++;
        if (g_l !== 1'b1 || {b, a} !== 2'd1) begin failures++; $display("FAIL en_hold: got G_L=%b sel=%0d required G_L=1 sel=1", g_l, {b, a}); end
        en = 1'b1;
        sb_q.push_back(2'd0); sb_q.push_back(2'd1);
        @(negedge clk);
        checks++;
        if (frame !== 1'b1) begin failures++; $display("FAIL en_restart_frame: got %b required 1", frame); end
        wait_drain(100);
        checks++;
        if (sb_q.size() !== 0 || g_l !== 1'b0) begin failures++; $display("FAIL en_restart: got %0d pending G_L=%b required 0 pending G_L=0", sb_q.size(), g_l); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (g_l !== 1'b1) begin failures++; $display("FAIL midreset_gl: got %b required 1", g_l); end
        checks++;
        if ({b, a} !== 2'b00 || frame !== 1'b0) begin failures++; $display("FAIL midreset_out: got sel=%b FRAME=%b required sel=00 FRAME=0", {b, a}, frame); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_mask_sparse();
        test_mask_zero();
        test_manual();
        test_en_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
